// File: rtl/krz_sys_arbiter.sv
// ---------------------------------------------------------------------------
// krz_sys_arbiter
//
// Two-master arbiter for the 24-bit system register bus (stb/ack). It shares
// the bus between the Kronos data-path requester (m0) and a second requester
// such as a loader or DMA engine (m1). Only one single-beat transaction is
// granted at a time. Priority is round-robin, and a watchdog aborts any
// transaction that the slave never acknowledges.
//
// Parameters
//   AWIDTH   address width shared by both masters and the slave
//   TIMEOUT  cycles a grant may wait for sys_ack_i (0 disables the watchdog)
//
// Ports
//   clk, RSTN                 clock, asynchronous active-low reset
//   mN_adr/dat/we/sel_i       master N request payload (N = 0, 1)
//   mN_stb_i                  master N request, held until mN_ack_o
//   mN_dat_o                  read data returned to master N
//   mN_ack_o                  one-cycle completion pulse to master N
//   mN_err_o                  qualifies mN_ack_o: the transaction timed out
//   sys_adr/dat/we/sel/stb_o  slave-side request, all zero outside a grant
//   sys_dat_i, sys_ack_i      slave read data and one-cycle acknowledge
//   busy_o                    a grant is active
//   tmo_cnt_o                 saturating count of timeouts since reset
// ---------------------------------------------------------------------------
module krz_sys_arbiter #(
   parameter int AWIDTH  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic [AWIDTH-1:0] m0_adr_i,
   input  logic [31:0]       m0_dat_i,
   input  logic              m0_we_i,
   input  logic [3:0]        m0_sel_i,
   input  logic              m0_stb_i,
   output logic [31:0]       m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic [AWIDTH-1:0] m1_adr_i,
   input  logic [31:0]       m1_dat_i,
   input  logic              m1_we_i,
   input  logic [3:0]        m1_sel_i,
   input  logic              m1_stb_i,
   output logic [31:0]       m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic [AWIDTH-1:0] sys_adr_o,
   output logic [31:0]       sys_dat_o,
   output logic              sys_we_o,
   output logic [3:0]        sys_sel_o,
   output logic              sys_stb_o,
   input  logic [31:0]       sys_dat_i,
   input  logic              sys_ack_i,
   output logic              busy_o,
   output logic [7:0]        tmo_cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   // The watchdog only has to reach TIMEOUT-1, so size it to that value.
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic          lastGrant_q, lastGrant_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic [7:0]    tmoCnt_q, tmoCnt_d;

   logic granted;
   logic grantIdx;
   logic tmoHit;
   logic ackOut;
   logic errOut;
   logic [31:0] datOut;

   // Grant decode and watchdog expiry. An ack in the expiry cycle takes
   // precedence, so the expiry condition requires the ack to be absent.
   always_comb begin
      granted  = (state_q == GNT0) || (state_q == GNT1);
      grantIdx = (state_q == GNT1);
      tmoHit   = (TIMEOUT > 0) && granted && !sys_ack_i && (wdog_q == WDOG_LAST);
   end

   // Next-state logic. In IDLE the request is only registered, so a grant
   // appears one cycle after the request is seen. When both masters ask,
   // the one that was not served last wins. Acks seen in IDLE are stale
   // (left over from a timed-out slave) and are ignored.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      wdog_d      = wdog_q;
      tmoCnt_d    = tmoCnt_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (m0_stb_i && (!m1_stb_i || lastGrant_q)) begin
               state_d = GNT0;
            end else if (m1_stb_i) begin
               state_d = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (sys_ack_i || tmoHit) begin
               state_d     = IDLE;
               lastGrant_d = grantIdx;
               if (tmoHit && (tmoCnt_q != 8'hFF)) begin
                  tmoCnt_d = tmoCnt_q + 8'd1;
               end
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset starts with last grant set to m1, so m0 wins
   // the first contended arbitration.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         wdog_q      <= '0;
         tmoCnt_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         wdog_q      <= wdog_d;
         tmoCnt_q    <= tmoCnt_d;
      end
   end

   // Bus steering. The strobe drops in the ack cycle so that a registered
   // slave never sees a second strobe, and drops on timeout as well. The
   // completion pulse goes only to the granted master. A timed-out
   // transaction returns zero data with the error flag set.
   always_comb begin
      sys_adr_o = '0;
      sys_dat_o = '0;
      sys_we_o  = 1'b0;
      sys_sel_o = 4'h0;
      sys_stb_o = 1'b0;
      m0_dat_o  = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_dat_o  = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      ackOut    = sys_ack_i || tmoHit;
      errOut    = tmoHit;
      datOut    = sys_ack_i ? sys_dat_i : 32'h0;
      if (granted) begin
         sys_stb_o = !sys_ack_i && !tmoHit;
         if (grantIdx) begin
            sys_adr_o = m1_adr_i;
            sys_dat_o = m1_dat_i;
            sys_we_o  = m1_we_i;
            sys_sel_o = m1_sel_i;
            m1_ack_o  = ackOut;
            m1_err_o  = errOut;
            m1_dat_o  = datOut;
         end else begin
            sys_adr_o = m0_adr_i;
            sys_dat_o = m0_dat_i;
            sys_we_o  = m0_we_i;
            sys_sel_o = m0_sel_i;
            m0_ack_o  = ackOut;
            m0_err_o  = errOut;
            m0_dat_o  = datOut;
         end
      end
   end

   assign busy_o    = granted;
   assign tmo_cnt_o = tmoCnt_q;

endmodule

// File: tb/tb_krz_sys_arbiter.sv
// ---------------------------------------------------------------------------
// tb_krz_sys_arbiter
//
// Directed bench for krz_sys_arbiter with a watchdog of 8 cycles. Inputs
// change 1 ns after the rising edge and outputs are sampled 3 ns after it.
// The slave is played by hand through sys_ack_i / sys_dat_i.
// ---------------------------------------------------------------------------
module tb_krz_sys_arbiter;

   logic        clk = 1'b0;
   logic        RSTN;
   logic [23:0] m0_adr, m1_adr;
   logic [31:0] m0_dati, m1_dati;
   logic        m0_we, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_stb, m1_stb;
   logic [31:0] m0_dato, m1_dato;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic [23:0] sys_adr;
   logic [31:0] sys_dato, sys_dati;
   logic        sys_we, sys_stb, sys_ack;
   logic [3:0]  sys_sel;
   logic        busy;
   logic [7:0]  tmoCnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   krz_sys_arbiter #(
      .AWIDTH (24),
      .TIMEOUT(8)
   ) dut (
      .clk      (clk),
      .RSTN     (RSTN),
      .m0_adr_i (m0_adr),
      .m0_dat_i (m0_dati),
      .m0_we_i  (m0_we),
      .m0_sel_i (m0_sel),
      .m0_stb_i (m0_stb),
      .m0_dat_o (m0_dato),
      .m0_ack_o (m0_ack),
      .m0_err_o (m0_err),
      .m1_adr_i (m1_adr),
      .m1_dat_i (m1_dati),
      .m1_we_i  (m1_we),
      .m1_sel_i (m1_sel),
      .m1_stb_i (m1_stb),
      .m1_dat_o (m1_dato),
      .m1_ack_o (m1_ack),
      .m1_err_o (m1_err),
      .sys_adr_o(sys_adr),
      .sys_dat_o(sys_dato),
      .sys_we_o (sys_we),
      .sys_sel_o(sys_sel),
      .sys_stb_o(sys_stb),
      .sys_dat_i(sys_dati),
      .sys_ack_i(sys_ack),
      .busy_o   (busy),
      .tmo_cnt_o(tmoCnt)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // One bus cycle: drive requests and slave response, then settle.
   task automatic applyStimulus(input logic s0, input logic s1, input logic ack,
                                input logic [31:0] sdat);
      nextCycle();
      m0_stb   = s0;
      m1_stb   = s1;
      sys_ack  = ack;
      sys_dati = sdat;
      #2;
   endtask

   task automatic resetDut();
      nextCycle();
      m0_stb   = 1'b0;
      m1_stb   = 1'b0;
      sys_ack  = 1'b0;
      sys_dati = 32'h0;
      RSTN     = 1'b0;
      #2;
      checkOutput("rst busy", busy, 0);
      checkOutput("rst sys_stb", sys_stb, 0);
      checkOutput("rst tmo_cnt", tmoCnt, 0);
      checkOutput("rst m0_ack", m0_ack, 0);
      checkOutput("rst m1_ack", m1_ack, 0);
      nextCycle();
      RSTN = 1'b1;
   endtask

   initial begin
      int pulses;
      int cycles;
      logic [31:0] d;
      RSTN    = 1'b0;
      m0_adr  = '0; m1_adr  = '0;
      m0_dati = '0; m1_dati = '0;
      m0_we   = 0;  m1_we   = 0;
      m0_sel  = 0;  m1_sel  = 0;
      m0_stb  = 0;  m1_stb  = 0;
      sys_ack = 0;  sys_dati = '0;

      // Test 1: single m0 write, slave acks one cycle after grant.
      resetDut();
      m0_adr = 24'h000004; m0_dati = 32'h1; m0_we = 1; m0_sel = 4'hF;
      applyStimulus(1, 0, 0, 32'h0);
      checkOutput("t1 req busy", busy, 0);
      checkOutput("t1 req stb", sys_stb, 0);
      applyStimulus(1, 0, 0, 32'h0);
      checkOutput("t1 gnt stb", sys_stb, 1);
      checkOutput("t1 gnt adr", sys_adr, 32'h4);
      checkOutput("t1 gnt dat", sys_dato, 32'h1);
      checkOutput("t1 gnt we", sys_we, 1);
      checkOutput("t1 gnt sel", sys_sel, 4'hF);
      checkOutput("t1 gnt m0_ack", m0_ack, 0);
      applyStimulus(1, 0, 1, 32'h0);
      checkOutput("t1 ack m0_ack", m0_ack, 1);
      checkOutput("t1 ack m0_err", m0_err, 0);
      checkOutput("t1 ack stb", sys_stb, 0);
      checkOutput("t1 ack m1_ack", m1_ack, 0);
      checkOutput("t1 ack m1_dat", m1_dato, 0);
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput("t1 idle busy", busy, 0);
      checkOutput("t1 idle adr", sys_adr, 0);

      // Test 2: both masters read continuously; grants alternate from m0.
      resetDut();
      m0_we = 0; m1_we = 0;
      m0_adr = 24'h000010; m1_adr = 24'h000020;
      applyStimulus(1, 1, 0, 32'h0);
      checkOutput("t2 req busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         d = 32'hA5000000 | i;
         applyStimulus(1, 1, 0, 32'h0);
         checkOutput("t2 gnt busy", busy, 1);
         checkOutput("t2 gnt adr", sys_adr, (i % 2 == 0) ? 32'h10 : 32'h20);
         applyStimulus(1, 1, 1, d);
         checkOutput("t2 m0_ack", m0_ack, (i % 2 == 0) ? 1 : 0);
         checkOutput("t2 m1_ack", m1_ack, (i % 2 == 0) ? 0 : 1);
         checkOutput("t2 m0_dat", m0_dato, (i % 2 == 0) ? d : 32'h0);
         checkOutput("t2 m1_dat", m1_dato, (i % 2 == 0) ? 32'h0 : d);
         applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 0, 32'h0);
         checkOutput("t2 idle busy", busy, 0);
      end

      // Test 3: m1 never acknowledged; error on the 8th grant cycle.
      resetDut();
      m1_adr = 24'h000030;
      applyStimulus(0, 1, 0, 32'hDEADBEEF);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, 1, 0, 32'hDEADBEEF);
         if (k < 7) begin
            checkOutput("t3 early m1_ack", m1_ack, 0);
            checkOutput("t3 early stb", sys_stb, 1);
         end else begin
            checkOutput("t3 tmo m1_ack", m1_ack, 1);
            checkOutput("t3 tmo m1_err", m1_err, 1);
            checkOutput("t3 tmo m1_dat", m1_dato, 0);
            checkOutput("t3 tmo stb", sys_stb, 0);
            checkOutput("t3 tmo cnt pre", tmoCnt, 0);
         end
      end
      applyStimulus(0, 0, 1, 32'hDEADBEEF);
      checkOutput("t3 stale m1_ack", m1_ack, 0);
      checkOutput("t3 stale m0_ack", m0_ack, 0);
      checkOutput("t3 stale m1_dat", m1_dato, 0);
      checkOutput("t3 stale busy", busy, 0);
      checkOutput("t3 tmo cnt", tmoCnt, 1);
      applyStimulus(0, 0, 0, 32'h0);

      // Test 4: ack lands in the watchdog expiry cycle; ack wins.
      m0_adr = 24'h000040;
      applyStimulus(1, 0, 0, 32'h0);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1, 0, 0, 32'h0);
         checkOutput("t4 wait m0_ack", m0_ack, 0);
      end
      applyStimulus(1, 0, 1, 32'h000055AA);
      checkOutput("t4 m0_ack", m0_ack, 1);
      checkOutput("t4 m0_err", m0_err, 0);
      checkOutput("t4 m0_dat", m0_dato, 32'h55AA);
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput("t4 busy", busy, 0);
      checkOutput("t4 tmo cnt", tmoCnt, 1);

      // Test 5: asynchronous reset in the middle of a GNT0 grant.
      applyStimulus(1, 0, 0, 32'h0);
      applyStimulus(1, 1, 0, 32'h0);
      checkOutput("t5 pre busy", busy, 1);
      checkOutput("t5 pre adr", sys_adr, 32'h40);
      #1;
      RSTN = 1'b0;
      #1;
      checkOutput("t5 rst busy", busy, 0);
      checkOutput("t5 rst stb", sys_stb, 0);
      checkOutput("t5 rst adr", sys_adr, 0);
      checkOutput("t5 rst tmo", tmoCnt, 0);
      applyStimulus(1, 1, 0, 32'h0);
      checkOutput("t5 held busy", busy, 0);
      RSTN = 1'b1;
      applyStimulus(1, 1, 0, 32'h0);
      checkOutput("t5 regrant busy", busy, 1);
      checkOutput("t5 regrant adr", sys_adr, 32'h40);
      applyStimulus(1, 1, 1, 32'h0);
      checkOutput("t5 m0_ack", m0_ack, 1);
      checkOutput("t5 m1_ack", m1_ack, 0);

      // Test 6: 300 back-to-back timeouts saturate the counter at 255.
      resetDut();
      pulses = 0;
      cycles = 0;
      while (pulses < 300 && cycles < 4000) begin
         applyStimulus(1, 0, 0, 32'h0);
         cycles++;
         if (m0_ack && m0_err) pulses++;
      end
      checkOutput("t6 pulses", pulses, 300);
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput("t6 tmo sat", tmoCnt, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
